// File: rtl/taus_urng_if.sv
`default_nettype none
// ============================================================================
// Module      : taus_urng_if
// Description : Seed-load, advance and output bundle of the taus88 uniform
//               random source.
// Revision    : 1.0 - initial release
// ============================================================================
interface taus_urng_if;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        en;
  logic [31:0] out_32;
  logic        out_valid;
  logic        busy;

  // Requester side: supplies seeds and advance requests, consumes words.
  modport master (
    output seed_valid, seed_data, en,
    input  out_32, out_valid, busy
  );

  // Generator side.
  modport slave (
    input  seed_valid, seed_data, en,
    output out_32, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/taus_urng.sv
`default_nettype none
// ============================================================================
// Module      : taus_urng
// Description : Three-component combined Tausworthe (taus88) uniform 32-bit
//               generator with a three-beat seed loader, a warm-up phase and
//               a one-word-per-cycle output strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module taus_urng #(
  parameter logic [31:0] SEED1  = 32'h0000_0002,
  parameter logic [31:0] SEED2  = 32'h0000_0008,
  parameter logic [31:0] SEED3  = 32'h0000_0010,
  parameter int unsigned WARMUP = 16
) (
  input  wire logic   clk,
  input  wire logic   reset,
  taus_urng_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Forcing one low-order bit per component keeps every state away from the
  // all-zero-in-significant-bits degenerate cycles.
  localparam logic [31:0] c_force1 = 32'h0000_0002;
  localparam logic [31:0] c_force2 = 32'h0000_0008;
  localparam logic [31:0] c_force3 = 32'h0000_0010;

  localparam logic [31:0] c_seed1 = SEED1 | c_force1;
  localparam logic [31:0] c_seed2 = SEED2 | c_force2;
  localparam logic [31:0] c_seed3 = SEED3 | c_force3;

  // A zero warm-up skips WARM entirely.
  localparam state_t      c_start      = (WARMUP == 0) ? ST_RUN : ST_WARM;
  localparam logic        c_start_busy = (WARMUP == 0) ? 1'b0 : 1'b1;
  localparam logic [15:0] c_warm_last  = (WARMUP == 0) ? 16'd0 : 16'(WARMUP - 1);

  state_t      r_state;
  logic [1:0]  r_beat;
  logic [15:0] r_warm_cnt;
  logic [31:0] r_s1;
  logic [31:0] r_s2;
  logic [31:0] r_s3;
  logic [31:0] r_out_32;
  logic        r_out_valid;
  logic        r_busy;

  logic [31:0] w_s1_nxt;
  logic [31:0] w_s2_nxt;
  logic [31:0] w_s3_nxt;
  logic [31:0] w_word_nxt;

  // One taus88 step of each component; shifts are logical and truncate.
  assign w_s1_nxt   = ((r_s1 & 32'hFFFF_FFFE) << 12) ^ (((r_s1 << 13) ^ r_s1) >> 19);
  assign w_s2_nxt   = ((r_s2 & 32'hFFFF_FFF8) << 4)  ^ (((r_s2 << 2)  ^ r_s2) >> 25);
  assign w_s3_nxt   = ((r_s3 & 32'hFFFF_FFF0) << 17) ^ (((r_s3 << 3)  ^ r_s3) >> 11);
  assign w_word_nxt = w_s1_nxt ^ w_s2_nxt ^ w_s3_nxt;

  // Seed loading, warm-up stepping and RUN stepping; a seed beat always
  // takes priority over a step in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1        <= c_seed1;
      r_s2        <= c_seed2;
      r_s3        <= c_seed3;
      r_state     <= c_start;
      r_busy      <= c_start_busy;
      r_beat      <= 2'd0;
      r_warm_cnt  <= 16'd0;
      r_out_32    <= 32'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.seed_valid) begin
        case (r_beat)
          2'd0:    r_s1 <= bus.seed_data | c_force1;
          2'd1:    r_s2 <= bus.seed_data | c_force2;
          default: r_s3 <= bus.seed_data | c_force3;
        endcase
        if (r_beat[1]) begin
          // Third beat completes the seed and restarts warm-up.
          r_beat     <= 2'd0;
          r_warm_cnt <= 16'd0;
          r_state    <= c_start;
          r_busy     <= c_start_busy;
        end else begin
          r_beat  <= r_beat + 2'd1;
          r_state <= ST_LOAD;
          r_busy  <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_WARM: begin
            r_s1 <= w_s1_nxt;
            r_s2 <= w_s2_nxt;
            r_s3 <= w_s3_nxt;
            if (r_warm_cnt == c_warm_last) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
            end else begin
              r_warm_cnt <= r_warm_cnt + 16'd1;
            end
          end
          ST_RUN: begin
            if (bus.en) begin
              r_s1        <= w_s1_nxt;
              r_s2        <= w_s2_nxt;
              r_s3        <= w_s3_nxt;
              r_out_32    <= w_word_nxt;
              r_out_valid <= 1'b1;
            end
          end
          default: ;  // LOAD waits for the remaining beats with no timeout
        endcase
      end
    end
  end

  assign bus.out_32    = r_out_32;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_taus_urng.sv
`default_nettype none
// ============================================================================
// Module      : tb_taus_urng
// Description : Scoreboard bench for taus_urng. Two instances (WARMUP=0 and
//               WARMUP=2) share one stimulus stream; a reference model pushes
//               expected words, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taus_urng;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  taus_urng_if bus0 ();
  taus_urng_if bus2 ();

  taus_urng #(.SEED1(32'h2), .SEED2(32'h8), .SEED3(32'h10), .WARMUP(0)) dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0.slave)
  );

  taus_urng #(.SEED1(32'h2), .SEED2(32'h8), .SEED3(32'h10), .WARMUP(2)) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2.slave)
  );

  // ---------------- reference model ----------------
  localparam logic [31:0] SEEDS  [3] = '{32'h2, 32'h8, 32'h10};
  localparam logic [31:0] FORCES [3] = '{32'h2, 32'h8, 32'h10};
  localparam int          PH_LOAD = 0, PH_WARM = 1, PH_RUN = 2;

  logic [31:0] ms      [2][3];
  int          m_phase [2];
  int          m_left  [2];
  int          m_beat  [2];
  logic        m_valid [2];
  logic [31:0] m_word  [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  int errors = 0;
  int checks = 0;

  function automatic int warm_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] comp(input logic [31:0] s, input logic [31:0] mask,
                                       input int c, input int a, input int b);
    return ((s & mask) << c) ^ (((s << a) ^ s) >> b);
  endfunction

  task automatic model_step(input int d);
    ms[d][0] = comp(ms[d][0], 32'hFFFF_FFFE, 12, 13, 19);
    ms[d][1] = comp(ms[d][1], 32'hFFFF_FFF8, 4, 2, 25);
    ms[d][2] = comp(ms[d][2], 32'hFFFF_FFF0, 17, 3, 11);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) ms[d][k] = SEEDS[k] | FORCES[k];
      m_phase[d] = (warm_of(d) == 0) ? PH_RUN : PH_WARM;
      m_left[d]  = warm_of(d);
      m_beat[d]  = 0;
      m_valid[d] = 1'b0;
      m_word[d]  = 32'd0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge(input logic sv, input logic [31:0] sd, input logic e);
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      if (sv) begin
        ms[d][m_beat[d]] = sd | FORCES[m_beat[d]];
        if (m_beat[d] == 2) begin
          m_beat[d]  = 0;
          m_left[d]  = warm_of(d);
          m_phase[d] = (warm_of(d) == 0) ? PH_RUN : PH_WARM;
        end else begin
          m_beat[d]  = m_beat[d] + 1;
          m_phase[d] = PH_LOAD;
        end
      end else if (m_phase[d] == PH_WARM) begin
        model_step(d);
        m_left[d] = m_left[d] - 1;
        if (m_left[d] == 0) m_phase[d] = PH_RUN;
      end else if (m_phase[d] == PH_RUN && e) begin
        model_step(d);
        m_word[d]  = ms[d][0] ^ ms[d][1] ^ ms[d][2];
        m_valid[d] = 1'b1;
        if (d == 0) q0.push_back(m_word[d]);
        else        q1.push_back(m_word[d]);
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input int d, input logic v, input logic [31:0] o, input logic b);
    logic [31:0] exp;
    chk($sformatf("out_valid[%0d]", d), {31'd0, v}, {31'd0, m_valid[d]});
    chk($sformatf("busy[%0d]", d), {31'd0, b}, {31'd0, (m_phase[d] != PH_RUN)});
    if (v) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL word[%0d]: got unexpected %h expected no word at %0t", d, o, $time);
      end else begin
        exp = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("word[%0d]", d), o, exp);
      end
    end else begin
      chk($sformatf("hold[%0d]", d), o, m_word[d]);
    end
  endtask

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    check_out(0, bus0.out_valid, bus0.out_32, bus0.busy);
    check_out(1, bus2.out_valid, bus2.out_32, bus2.busy);
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic sv, input logic [31:0] sd, input logic e);
    bus0.seed_valid = sv;  bus0.seed_data = sd;  bus0.en = e;
    bus2.seed_valid = sv;  bus2.seed_data = sd;  bus2.en = e;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(sv, sd, e);
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_valid0", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst_busy0",  {31'd0, bus0.busy},      32'd0);
    chk("rst_busy2",  {31'd0, bus2.busy},      32'd1);
    chk("rst_out0",   bus0.out_32,             32'd0);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    bus0.seed_valid = 1'b0;  bus0.seed_data = 32'd0;  bus0.en = 1'b0;
    bus2.seed_valid = 1'b0;  bus2.seed_data = 32'd0;  bus2.en = 1'b0;

    // Reset with en high.
    cycle(1'b0, 32'd0, 1'b1);
    chk("reset_busy0",  {31'd0, bus0.busy},      32'd0);
    chk("reset_valid0", {31'd0, bus0.out_valid}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1);
    rst = 1'b0;

    cycle(1'b0, 32'd0, 1'b1);
    chk("first_word",  bus0.out_32, 32'h0020_2080);
    cycle(1'b0, 32'd0, 1'b1);
    chk("second_word", bus0.out_32, 32'h0200_2C80);
    cycle(1'b0, 32'd0, 1'b1);
    chk("warm_first_word", bus2.out_32, 32'h4808_8062);

    // en gap 1,0,0,1.
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);

    // Reseed with zeros: forced back to 2/8/16.
    cycle(1'b1, 32'd0, 1'b0);
    cycle(1'b1, 32'd0, 1'b0);
    cycle(1'b1, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("reseed_word1", bus0.out_32, 32'h0020_2080);
    cycle(1'b0, 32'd0, 1'b1);
    chk("reseed_word2", bus0.out_32, 32'h0200_2C80);
    repeat (3) cycle(1'b0, 32'd0, 1'b1);

    // Seed beat together with en in RUN.
    cycle(1'b1, $urandom, 1'b1);
    chk("collide_busy0",  {31'd0, bus0.busy},      32'd1);
    chk("collide_valid0", {31'd0, bus0.out_valid}, 32'd0);
    cycle(1'b1, $urandom, 1'($urandom_range(0, 1)));
    cycle(1'b1, $urandom, 1'($urandom_range(0, 1)));
    repeat (6) cycle(1'b0, 32'd0, 1'b1);

    // Randomised run with occasional seed beats.
    for (int i = 0; i < 400; i++)
      cycle(1'(($urandom % 12) == 0), $urandom, 1'(($urandom % 4) != 0));

    // Complete any partial seed, then run.
    for (int i = 0; i < 2 && m_beat[0] != 0; i++) cycle(1'b1, $urandom, 1'b0);
    repeat (4) cycle(1'b0, 32'd0, 1'b1);

    // Asynchronous reset after a single seed beat.
    cycle(1'b1, $urandom, 1'b0);
    async_reset();
    cycle(1'b0, 32'd0, 1'b1);
    chk("post_reset_word1", bus0.out_32, 32'h0020_2080);
    cycle(1'b0, 32'd0, 1'b1);
    chk("post_reset_word2", bus0.out_32, 32'h0200_2C80);
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'd0, 1'(($urandom % 3) != 0));

    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
